// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions for the receive (and future transmit) path.
//   uart_rx_state_t  receiver FSM state encoding
//   clks_per_bit()   system clocks per serial bit for a given clock and baud
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

   // Integer division: the bit period is truncated to whole clock cycles
   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: generic two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, active-high (both flops load RST_VAL)
//   d    in   asynchronous input
//   q    out  synchronized output, two cycles of latency
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// Purpose: 8N1-style UART receiver; turns the serial line into parallel bytes
//   with a one-cycle valid strobe and flags framing errors.
// Ports:
//   iCLK_50     in   system clock, rising edge
//   iRST        in   synchronous reset, active-high
//   iUART_RXD   in   raw serial line (asynchronous, idle high)
//   oDATA       out  last good byte, LSB = first bit received
//   oVALID      out  1-cycle pulse when oDATA is updated
//   oFRAME_ERR  out  1-cycle pulse when the stop bit is sampled low
//   oBUSY       out  high whenever the receiver is not idle
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 iCLK_50,
   input  logic                 iRST,
   input  logic                 iUART_RXD,
   output logic [DATA_BITS-1:0] oDATA,
   output logic                 oVALID,
   output logic                 oFRAME_ERR,
   output logic                 oBUSY
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   uart_rx_state_t       state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;

   // Reset to 1 so the line reads idle and no false start follows reset
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (iCLK_50),
      .rst (iRST),
      .d   (iUART_RXD),
      .q   (rx_s)
   );

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Re-check the start bit at its middle to reject glitches
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  state_d   = STOP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BREAK: begin
            // A held-low line must return high before a new frame is accepted
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge iCLK_50) begin
      if (iRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign oDATA      = data_q;
   assign oVALID     = valid_q;
   assign oFRAME_ERR = ferr_q;
   assign oBUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Purpose: directed self-checking bench for uart_rx_byte at default parameters.
module tb_uart_rx_byte;

   localparam int unsigned CPB   = 434;
   localparam int unsigned HALF  = 217;
   localparam int unsigned FRAME = 10 * CPB;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       busy;

   int unsigned n_checks;
   int unsigned n_fail;

   // Monitor state
   int unsigned cyc;
   int unsigned valid_cnt;
   int unsigned ferr_cnt;
   int unsigned viol_cnt;
   int unsigned last_valid_cyc;
   int unsigned prev_valid_cyc;
   int unsigned tx_start_cyc;
   logic [7:0]  rx_bytes[$];
   logic        pulse_prev;

   uart_rx_byte #(
      .CLK_HZ    (50_000_000),
      .BAUD      (115200),
      .DATA_BITS (8)
   ) dut (
      .iCLK_50    (clk),
      .iRST       (rst),
      .iUART_RXD  (rxd),
      .oDATA      (data),
      .oVALID     (valid),
      .oFRAME_ERR (ferr),
      .oBUSY      (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Sample outputs 1 time unit after each rising edge
   initial begin
      cyc        = 0;
      valid_cnt  = 0;
      ferr_cnt   = 0;
      viol_cnt   = 0;
      pulse_prev = 1'b0;
      last_valid_cyc = 0;
      prev_valid_cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (valid === 1'b1 && ferr === 1'b1) viol_cnt++;
         if (pulse_prev && (valid === 1'b1 || ferr === 1'b1)) viol_cnt++;
         pulse_prev = (valid === 1'b1) || (ferr === 1'b1);
         if (valid === 1'b1) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            rx_bytes.push_back(data);
         end
         if (ferr === 1'b1) ferr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a 10-bit frame LSB-first, one bit per CPB cycles, for n_cyc cycles
   task automatic tx_bits(input logic [9:0] frame, input int unsigned n_cyc);
      for (int unsigned i = 0; i < n_cyc; i++) begin
         @(negedge clk);
         rxd = frame[i / CPB];
         if (i == 0) tx_start_cyc = cyc;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      tx_bits({stop_bit, b, 1'b0}, FRAME);
   endtask

   task automatic hold(input logic v, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         rxd = v;
      end
   endtask

   int unsigned v0, f0, wait_n;
   int          dly;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      rxd      = 1'b1;

      // 1: reset then idle line
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(1'b1, 1000);
      check("rst_data",  32'(data),  32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_ferr",  32'(ferr),  32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("idle_no_valid", valid_cnt, 0);
      check("idle_no_ferr",  ferr_cnt,  0);

      // 2: single byte 0xA5
      rx_bytes.delete();
      send_byte(8'hA5, 1'b1);
      hold(1'b1, 20);
      check("a5_count", valid_cnt, 1);
      check("a5_data",  32'(data), 32'hA5);
      check("a5_ferr",  ferr_cnt,  0);
      dly = int'(last_valid_cyc) - int'(tx_start_cyc) - 4124;
      check("a5_latency_ok", 32'((dly >= -3) && (dly <= 3)), 32'h1);
      check("a5_busy_idle", 32'(busy), 32'h0);

      // 3: 0x00 then 0xFF back-to-back
      rx_bytes.delete();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      hold(1'b1, 20);
      check("b2b_count", rx_bytes.size(), 2);
      if (rx_bytes.size() == 2) begin
         check("b2b_byte0", 32'(rx_bytes[0]), 32'h00);
         check("b2b_byte1", 32'(rx_bytes[1]), 32'hFF);
      end
      check("b2b_spacing", last_valid_cyc - prev_valid_cyc, FRAME);

      // 4: 0x3C with low stop bit, then line held low (break)
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_byte(8'h3C, 1'b0);
      hold(1'b0, 2000);
      check("brk_ferr_count", ferr_cnt - f0, 1);
      check("brk_no_valid",   valid_cnt - v0, 0);
      check("brk_data_kept",  32'(data), 32'hFF);
      check("brk_busy_held",  32'(busy), 32'h1);
      hold(1'b1, 6);
      check("brk_busy_release", 32'(busy), 32'h0);
      check("brk_ferr_final", ferr_cnt - f0, 1);

      // 5: short glitch shorter than half a bit
      v0 = valid_cnt;
      f0 = ferr_cnt;
      hold(1'b0, 100);
      check("glitch_busy_start", 32'(busy), 32'h1);
      wait_n = 0;
      while (busy !== 1'b0 && wait_n < HALF + 3) begin
         hold(1'b1, 1);
         wait_n++;
      end
      check("glitch_busy_clear", 32'(busy), 32'h0);
      hold(1'b1, 500);
      check("glitch_no_valid", valid_cnt - v0, 0);
      check("glitch_no_ferr",  ferr_cnt - f0,  0);

      // 6: reset during bit 4 of 0x5A, then 0x81
      v0 = valid_cnt;
      f0 = ferr_cnt;
      tx_bits({1'b1, 8'h5A, 1'b0}, 5 * CPB + 200);
      @(negedge clk);
      rxd = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data",  32'(data), 32'h0);
      check("mid_rst_busy",  32'(busy), 32'h0);
      hold(1'b1, 1000);
      check("abort_no_valid", valid_cnt - v0, 0);
      check("abort_no_ferr",  ferr_cnt - f0,  0);
      send_byte(8'h81, 1'b1);
      hold(1'b1, 20);
      check("post_rst_count", valid_cnt - v0, 1);
      check("post_rst_data",  32'(data), 32'h81);

      check("pulse_rules", viol_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
